// File: rtl/aes_pkg.sv
// Shared definitions for the AES step-display block: word width and the
// display controller's state encoding.
package aes_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SHOW = 2'd2,
    HOLD = 2'd3
  } state_e;

endpackage

// File: rtl/edge_sync.sv
// Synchronises an asynchronous level into the Clkin domain and emits a
// registered one-cycle pulse for each rising edge of that level.
// Nothing is reported until the chain holds real samples, so a level that is
// already high when reset releases is not mistaken for a rising edge.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clkin,
  input  logic rst_n,
  input  logic async_in,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;
  // fill_q[k] is set once k+1 edges have passed since reset; fill_q[SYNC_STAGES]
  // means last_q now holds a genuine sample of async_in.
  logic [SYNC_STAGES:0]   fill_q;

  // Synchroniser chain, previous-value flop, arming shift register and tick.
  always_ff @(posedge Clkin or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
      fill_q <= '0;
      tick   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      last_q <= sync_q[SYNC_STAGES-1];
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      tick   <= fill_q[SYNC_STAGES] & sync_q[SYNC_STAGES-1] & ~last_q;
    end
  end

endmodule

// File: rtl/aes_step_display.sv
// Captures DEPTH intermediate AES state words from the cipher core, then
// steps through them one word per slow_clk rising edge for the display.
//
// Input handshake: a word transfers on every Clkin edge where in_valid and
// in_ready are both high. in_ready is a registered decode of the LOAD state,
// so it never depends combinationally on in_valid; the core may hold in_valid
// high with stable in_data for as long as it likes. A start pulse in the same
// cycle cancels the transfer: that word is dropped.
module aes_step_display
  import aes_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int IDX_W       = $clog2(DEPTH)
) (
  input  logic              Clkin,
  input  logic              rst_n,
  input  logic              slow_clk,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic [WORD_W-1:0] disp_data,
  output logic [IDX_W-1:0]  disp_idx,
  output logic              disp_valid,
  output logic              done,
  output logic              tick,
  output logic [1:0]        dbg_state
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  state_e             state;
  state_e             state_n;
  logic [IDX_W-1:0]   wptr;
  logic [IDX_W-1:0]   rptr;
  logic [IDX_W-1:0]   rptr_inc;
  logic [WORD_W-1:0]  mem [DEPTH];
  logic               accept;

  assign dbg_state = state;
  assign rptr_inc  = rptr + 1'b1;
  // start wins over a simultaneous handshake.
  assign accept    = in_valid & in_ready & ~start;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .Clkin   (Clkin),
    .rst_n   (rst_n),
    .async_in(slow_clk),
    .tick    (tick)
  );

  // Next-state decode; start overrides everything, including a same-cycle tick.
  always_comb begin
    state_n = state;
    if (start) begin
      state_n = LOAD;
    end else begin
      case (state)
        IDLE:    state_n = IDLE;
        LOAD:    if (accept && wptr == LAST) state_n = SHOW;
        SHOW:    if (tick && rptr == LAST) state_n = HOLD;
        HOLD:    state_n = HOLD;
        default: state_n = IDLE;
      endcase
    end
  end

  // Capture buffer: written only by accepted words while loading.
  always_ff @(posedge Clkin) begin
    if (accept) mem[wptr] <= in_data;
  end

  // State, pointers and registered display outputs.
  always_ff @(posedge Clkin or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      disp_data  <= '0;
      disp_idx   <= '0;
      disp_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state    <= state_n;
      in_ready <= (state_n == LOAD);
      if (start) begin
        wptr       <= '0;
        rptr       <= '0;
        disp_idx   <= '0;
        disp_valid <= 1'b0;
        done       <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (accept) begin
              if (wptr == LAST) begin
                // Word 0 was stored earlier, so it can be shown straight away.
                rptr       <= '0;
                disp_idx   <= '0;
                disp_data  <= mem[0];
                disp_valid <= 1'b1;
              end else begin
                wptr <= wptr + 1'b1;
              end
            end
          end
          SHOW: begin
            if (tick) begin
              if (rptr != LAST) begin
                rptr      <= rptr_inc;
                disp_idx  <= rptr_inc;
                disp_data <= mem[rptr_inc];
              end else begin
                done <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_step_display.sv
// Self-checking bench for aes_step_display: directed scenarios followed by
// randomized capture/step/abort sequences against a word-list model.
module tb_aes_step_display;

  localparam int DEPTH = 4;
  localparam int S     = 2;
  localparam int IDX_W = 2;
  localparam int VW    = 2 + IDX_W + 16;

  // ---------------- clock / reset ----------------
  logic        Clkin = 1'b0;
  logic        rst_n = 1'b0;
  logic        slow_clk = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        in_ready;
  logic [15:0] disp_data;
  logic [IDX_W-1:0] disp_idx;
  logic        disp_valid;
  logic        done;
  logic        tick;
  logic [1:0]  dbg_state;

  always #5 Clkin = ~Clkin;

  int cyc = 0;
  always @(posedge Clkin) cyc <= cyc + 1;

  aes_step_display #(.DEPTH(DEPTH), .SYNC_STAGES(S), .IDX_W(IDX_W)) dut (
    .Clkin(Clkin), .rst_n(rst_n), .slow_clk(slow_clk), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .disp_data(disp_data), .disp_idx(disp_idx), .disp_valid(disp_valid),
    .done(done), .tick(tick), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [VW-1:0] exp_q[$];   // {valid, done, idx, data}
  int            tick_q[$];  // cycle number at which each tick must be seen

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 collecting words, 2 stepping through words, 3 holding last
  int          mode = 0;
  int          pos = 0;
  logic [15:0] cap[$];

  function automatic void model_start();
    if (mode >= 2) exp_q.push_back({1'b0, 1'b0, {IDX_W{1'b0}}, 16'h0});
    cap.delete();
    mode = 1;
    pos  = 0;
  endfunction

  function automatic void model_accept(input logic [15:0] w);
    cap.push_back(w);
    if (cap.size() == DEPTH) begin
      mode = 2;
      pos  = 0;
      exp_q.push_back({1'b1, 1'b0, IDX_W'(0), cap[0]});
    end
  endfunction

  function automatic void model_tick();
    if (mode == 2) begin
      if (pos < DEPTH - 1) begin
        pos++;
        exp_q.push_back({1'b1, 1'b0, IDX_W'(pos), cap[pos]});
      end else begin
        mode = 3;
        exp_q.push_back({1'b1, 1'b1, IDX_W'(pos), cap[pos]});
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  // One Clkin cycle: drive inputs, let the model predict this edge, then
  // check that in_ready tracks "collecting words".
  task automatic cycle(input bit st, input bit v, input logic [15:0] d, input bit tk);
    start    = st;
    in_valid = v;
    in_data  = d;
    if (st) model_start();
    else begin
      if (tk) model_tick();
      if (v && mode == 1) model_accept(d);
    end
    @(posedge Clkin); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    check("in_ready", in_ready, (mode == 1));
  endtask

  // One slow_clk period; the tick is seen S+1 edges after the rising edge,
  // optionally with a coincident start.
  task automatic do_tick(input bit st);
    slow_clk = 1'b1;
    tick_q.push_back(cyc + S + 1);
    repeat (S + 1) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    cycle(st, 1'b0, 16'h0, 1'b1);
    slow_clk = 1'b0;
    repeat (S + 3) cycle(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic capture_words(input logic [15:0] w0, input logic [15:0] w1,
                               input logic [15:0] w2, input logic [15:0] w3);
    cycle(1'b0, 1'b1, w0, 1'b0);
    cycle(1'b0, 1'b1, w1, 1'b0);
    cycle(1'b0, 1'b1, w2, 1'b0);
    cycle(1'b0, 1'b1, w3, 1'b0);
  endtask

  // ---------------- monitor ----------------
  logic [VW-1:0] last_view = '0;

  always @(negedge Clkin) begin
    logic [VW-1:0] view;
    logic [VW-1:0] e;
    view = {disp_valid, done, disp_idx, disp_data};
    if (tick === 1'b1) begin
      if (tick_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL tick_unexpected: got tick=1 expected none (cycle %0d)", cyc);
      end else begin
        check("tick_cycle", cyc, tick_q.pop_front());
      end
    end
    if (view !== last_view && (disp_valid === 1'b1 || last_view[VW-1] === 1'b1)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL display_unexpected: got %h expected no change (cycle %0d)", view, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e[VW-1]) check("display", view, e);
        else check("display_off", view[VW-1 -: 2], e[VW-1 -: 2]);
      end
    end
    last_view = view;
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset with slow_clk toggling: no tick, outputs at reset values.
    repeat (6) begin
      @(negedge Clkin);
      slow_clk = ~slow_clk;
    end
    @(negedge Clkin);
    check("rst_in_ready",   in_ready,   0);
    check("rst_disp_data",  disp_data,  16'h0000);
    check("rst_disp_idx",   disp_idx,   0);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_done",       done,       0);
    check("rst_tick",       tick,       0);

    // Release with slow_clk already high: must not tick.
    slow_clk = 1'b1;
    @(posedge Clkin); #1;
    rst_n = 1'b1;
    repeat (10) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    slow_clk = 1'b0;
    repeat (S + 3) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    // Tick while idle changes nothing on the display.
    do_tick(1'b0);

    // Normal run with the reference words.
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    capture_words(16'h9C63, 16'hC3F0, 16'h7A21, 16'h1D5E);
    repeat (4) do_tick(1'b0);
    do_tick(1'b0);   // held: no effect

    // Backpressure: in_valid 1,0,1,0 with junk on the gaps.
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 2 * DEPTH; i++)
      cycle(1'b0, (i % 2 == 0), 16'(16'h1000 + i * 16'h0111), 1'b0);

    // Abort during SHOW at index 2, then recapture.
    do_tick(1'b0);
    do_tick(1'b0);
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    capture_words(16'hA001, 16'hA002, 16'hA003, 16'hA004);
    do_tick(1'b0);

    // start coincident with tick in SHOW: back to LOAD, no step.
    do_tick(1'b1);
    // Tick during LOAD is ignored.
    do_tick(1'b0);
    // start coincident with a handshake: that word is dropped.
    cycle(1'b0, 1'b1, 16'hBEEF, 1'b0);
    cycle(1'b1, 1'b1, 16'hDEAD, 1'b0);
    capture_words(16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04);
    repeat (4) do_tick(1'b0);

    // Tick spacing: 40-cycle half-period, one tick per period.
    for (int p = 0; p < 4; p++) begin
      slow_clk = 1'b1;
      tick_q.push_back(cyc + S + 1);
      repeat (40) cycle(1'b0, 1'b0, 16'h0, 1'b0);
      slow_clk = 1'b0;
      repeat (40) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    end

    // Randomized capture / step / abort sequences.
    for (int it = 0; it < 30; it++) begin
      int abort_at;
      bit aborted;
      int nt;
      abort_at = $urandom_range(0, 7);
      aborted  = 1'b0;
      cycle(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
      while (mode == 1) begin
        if (!aborted && cap.size() == abort_at) begin
          cycle(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
          aborted = 1'b1;
        end else begin
          cycle(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
        end
      end
      nt = $urandom_range(0, DEPTH + 1);
      for (int t = 0; t < nt; t++) do_tick(($urandom_range(0, 7) == 0));
    end

    repeat (10) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    check("exp_q_drained",  exp_q.size(),  0);
    check("tick_q_drained", tick_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog: the run must end on its own.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
